// File: rtl/mips_run_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_run_controller : CPU reset/run sequencer ending on tohost, hang or timeout
// Revision 1.0
// ---------------------------------------------------------------------------
module mips_run_controller #(
  parameter int                    RST_CYCLES  = 2,
  parameter int                    MAX_CYCLES  = 1500,
  parameter int                    HALT_REPEAT = 4,
  parameter int                    PC_WIDTH    = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 'h0000_FFFC,
  parameter int                    CNT_WIDTH   = 32,
  parameter bit                    AUTO_START  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst,
  output logic                  running,
  output logic                  done,
  output logic [2:0]            status,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int HCW = $clog2(HALT_REPEAT + 2);

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_FAIL    = 3'd2;
  localparam logic [2:0] ST_HANG    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  if (MAX_CYCLES == 0) begin : g_max_cycles_check
    $error("mips_run_controller: MAX_CYCLES must be nonzero");
  end

  state_e                state_q, state_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  running_q, running_d;
  logic                  done_q, done_d;
  logic [2:0]            status_q, status_d;
  logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [RCW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [HCW-1:0]        hang_cnt_q, hang_cnt_d;
  logic [PC_WIDTH-1:0]   pc_prev_q, pc_prev_d;
  logic                  pc_valid_q, pc_valid_d;

  logic [CNT_WIDTH:0]    cc_ext;
  logic [CNT_WIDTH-1:0]  cc_next;
  logic [HCW-1:0]        hang_next;
  logic                  tohost_hit, hang_hit, timeout_hit, enter_reset;

  // Terminator conditions, evaluated against the value cycle_count is about to take
  always_comb begin
    cc_ext      = {1'b0, cycle_count_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
    cc_next     = cc_ext[CNT_WIDTH] ? cycle_count_q : cc_ext[CNT_WIDTH-1:0];
    timeout_hit = (cc_ext == (CNT_WIDTH+1)'(MAX_CYCLES));
    tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
    hang_next   = '0;
    if (pc_valid_q && (pc == pc_prev_q)) begin
      hang_next = (hang_cnt_q == {HCW{1'b1}}) ? hang_cnt_q : hang_cnt_q + 1'b1;
    end
    hang_hit = (HALT_REPEAT != 0) && (hang_next == HCW'(HALT_REPEAT));
  end

  always_comb begin
    state_d       = state_q;
    cpu_rst_d     = cpu_rst_q;
    running_d     = running_q;
    done_d        = done_q;
    status_d      = status_q;
    cycle_count_d = cycle_count_q;
    result_d      = result_q;
    rst_cnt_d     = rst_cnt_q;
    hang_cnt_d    = hang_cnt_q;
    pc_prev_d     = pc_prev_q;
    pc_valid_d    = pc_valid_q;
    enter_reset   = 1'b0;

    case (state_q)
      S_IDLE: begin
        enter_reset = start | AUTO_START;
      end
      S_RESET: begin
        cpu_rst_d = 1'b1;
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
          running_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        cycle_count_d = cc_next;
        pc_prev_d     = pc;
        pc_valid_d    = 1'b1;
        hang_cnt_d    = hang_next;
        if (tohost_hit || hang_hit || timeout_hit) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          running_d = 1'b0;
          cpu_rst_d = 1'b1;
          if (tohost_hit) begin
            result_d = mem_wdata;
            status_d = (mem_wdata == DATA_WIDTH'(1)) ? ST_PASS : ST_FAIL;
          end else if (hang_hit) begin
            status_d = ST_HANG;
          end else begin
            status_d = ST_TIMEOUT;
          end
        end
      end
      S_DONE: begin
        enter_reset = start;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every run, including a restart from DONE, begins from a clean slate
    if (enter_reset) begin
      state_d       = S_RESET;
      cpu_rst_d     = 1'b1;
      running_d     = 1'b0;
      done_d        = 1'b0;
      status_d      = ST_NONE;
      cycle_count_d = '0;
      result_d      = '0;
      rst_cnt_d     = '0;
      hang_cnt_d    = '0;
      pc_valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cpu_rst_q     <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= ST_NONE;
      cycle_count_q <= '0;
      result_q      <= '0;
      rst_cnt_q     <= '0;
      hang_cnt_q    <= '0;
      pc_prev_q     <= '0;
      pc_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_rst_q     <= cpu_rst_d;
      running_q     <= running_d;
      done_q        <= done_d;
      status_q      <= status_d;
      cycle_count_q <= cycle_count_d;
      result_q      <= result_d;
      rst_cnt_q     <= rst_cnt_d;
      hang_cnt_q    <= hang_cnt_d;
      pc_prev_q     <= pc_prev_d;
      pc_valid_q    <= pc_valid_d;
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign status      = status_q;
  assign cycle_count = cycle_count_q;
  assign result      = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_run_controller : directed checks of run sequencing and terminators
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mips_run_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  logic        cpu_rst0, running0, done0;
  logic [2:0]  status0;
  logic [31:0] cycle_count0, result0;
  logic        cpu_rst1, running1, done1;
  logic [2:0]  status1;
  logic [31:0] cycle_count1, result1;

  int total = 0;
  int bad   = 0;

  // Hang detection enabled
  mips_run_controller #(
    .RST_CYCLES(2), .MAX_CYCLES(10), .HALT_REPEAT(4), .AUTO_START(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst0),
    .running(running0), .done(done0), .status(status0),
    .cycle_count(cycle_count0), .result(result0)
  );

  // Hang detection disabled, same stimulus
  mips_run_controller #(
    .RST_CYCLES(2), .MAX_CYCLES(10), .HALT_REPEAT(0), .AUTO_START(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst1),
    .running(running1), .done(done1), .status(status1),
    .cycle_count(cycle_count1), .result(result1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [31:0] p, input logic we, input logic [31:0] a,
                      input logic [31:0] d);
    pc        = p;
    mem_we    = we;
    mem_addr  = a;
    mem_wdata = d;
    @(posedge clk);
    #1;
  endtask

  // start pulse from DONE, then the two RESET edges; leaves both DUTs in RUN
  task automatic restart();
    start = 1'b1;
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    start = 1'b0;
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pc = '0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    @(posedge clk);
    #1;
    chk("rst_cpu_rst", cpu_rst0, 1);
    chk("rst_running", running0, 0);
    chk("rst_done", done0, 0);
    chk("rst_status", status0, 0);
    chk("rst_cc", cycle_count0, 0);
    chk("rst_result", result0, 0);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    // Timeout run: IDLE->RESET, two RESET edges, then ten RUN edges
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    chk("t1_cpu_rst_idle_exit", cpu_rst0, 1);
    chk("t1_running_reset", running0, 0);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    chk("t1_cpu_rst_reset1", cpu_rst0, 1);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    chk("t1_cpu_rst_run", cpu_rst0, 0);
    chk("t1_running_run", running0, 1);
    chk("t1_cc_run0", cycle_count0, 0);
    for (int i = 1; i <= 9; i++) tick(32'(4 * (i - 1)), 1'b0, 32'h0, 32'h0);
    chk("t1_cc9", cycle_count0, 9);
    chk("t1_done9", done0, 0);
    tick(32'd36, 1'b0, 32'h0, 32'h0);
    chk("t1_done", done0, 1);
    chk("t1_status", status0, 4);
    chk("t1_cc", cycle_count0, 10);
    chk("t1_running", running0, 0);
    chk("t1_cpu_rst", cpu_rst0, 1);
    chk("t1_dut1_status", status1, 4);
    tick(32'd40, 1'b0, 32'h0, 32'h0);
    chk("t1_cc_hold", cycle_count0, 10);
    chk("t1_cpu_rst_hold", cpu_rst0, 1);

    // PASS write on RUN cycle 5; later activity must not disturb DONE
    start = 1'b1;
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    start = 1'b0;
    chk("t2_done_clr", done0, 0);
    chk("t2_status_clr", status0, 0);
    chk("t2_cc_clr", cycle_count0, 0);
    chk("t2_cpu_rst", cpu_rst0, 1);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i <= 4; i++) tick(32'(4 * (i - 1)), 1'b0, 32'h0, 32'h0);
    chk("t2_done4", done0, 0);
    tick(32'd16, 1'b1, 32'hFFFC, 32'h1);
    chk("t2_status", status0, 1);
    chk("t2_result", result0, 1);
    chk("t2_cc", cycle_count0, 5);
    chk("t2_done", done0, 1);
    tick(32'd20, 1'b1, 32'hFFFC, 32'hDEAD);
    tick(32'd24, 1'b1, 32'hFFFC, 32'h2);
    chk("t2_status_hold", status0, 1);
    chk("t2_result_hold", result0, 1);
    chk("t2_cc_hold", cycle_count0, 5);
    chk("t2_done_hold", done0, 1);
    chk("t2_running_hold", running0, 0);

    // FAIL write; near-miss address ignored
    restart();
    tick(32'h0, 1'b1, 32'hFFF8, 32'h1);
    chk("t3_near_miss_done", done0, 0);
    chk("t3_near_miss_status", status0, 0);
    tick(32'h4, 1'b1, 32'hFFFC, 32'hDEAD);
    chk("t3_status", status0, 2);
    chk("t3_result", result0, 32'hDEAD);
    chk("t3_cc", cycle_count0, 2);

    // Hang: pc stuck at 0x40 from RUN cycle 3
    restart();
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    tick(32'h4, 1'b0, 32'h0, 32'h0);
    for (int i = 3; i <= 6; i++) tick(32'h40, 1'b0, 32'h0, 32'h0);
    chk("t4_done6", done0, 0);
    tick(32'h40, 1'b0, 32'h0, 32'h0);
    chk("t4_status", status0, 3);
    chk("t4_cc", cycle_count0, 7);
    chk("t4_done", done0, 1);
    chk("t4_dut1_running", running1, 1);
    for (int i = 8; i <= 10; i++) tick(32'h40, 1'b0, 32'h0, 32'h0);
    chk("t4_dut1_status", status1, 4);
    chk("t4_dut1_cc", cycle_count1, 10);
    chk("t4_status_hold", status0, 3);
    chk("t4_cc_hold", cycle_count0, 7);

    // Priority: tohost, hang and timeout all on RUN edge 10
    restart();
    for (int i = 1; i <= 5; i++) tick(32'(4 * (i - 1)), 1'b0, 32'h0, 32'h0);
    for (int i = 6; i <= 9; i++) tick(32'h80, 1'b0, 32'h0, 32'h0);
    chk("t5_done9", done0, 0);
    tick(32'h80, 1'b1, 32'hFFFC, 32'h1);
    chk("t5_status", status0, 1);
    chk("t5_cc", cycle_count0, 10);
    chk("t5_result", result0, 1);
    chk("t5_dut1_status", status1, 1);

    // Asynchronous abort mid-RUN, auto restart, then a start from DONE
    restart();
    for (int i = 1; i <= 6; i++) tick(32'(4 * (i - 1)), 1'b0, 32'h0, 32'h0);
    chk("t6_cc6", cycle_count0, 6);
    rst = 1'b1;
    #1;
    chk("t6_async_cc", cycle_count0, 0);
    chk("t6_async_running", running0, 0);
    chk("t6_async_cpu_rst", cpu_rst0, 1);
    chk("t6_async_status", status0, 0);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    chk("t6_rerun_running", running0, 1);
    chk("t6_rerun_cc0", cycle_count0, 0);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    chk("t6_rerun_cc1", cycle_count0, 1);
    for (int i = 2; i <= 10; i++) tick(32'(4 * (i - 1)), 1'b0, 32'h0, 32'h0);
    chk("t6_timeout", status0, 4);
    start = 1'b1;
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    start = 1'b0;
    chk("t6_restart_done", done0, 0);
    chk("t6_restart_status", status0, 0);
    chk("t6_restart_cpu_rst", cpu_rst0, 1);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    chk("t6_restart_cpu_rst2", cpu_rst0, 1);
    tick(32'h0, 1'b0, 32'h0, 32'h0);
    chk("t6_restart_run", cpu_rst0, 0);
    chk("t6_restart_running", running0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
